// File: rtl/balance_seq_pkg.sv
// Shared state encoding, threshold defaults and timer sizing for the balance run-mode sequencer.
// Overspeed shutdown defaults exist only when TOO_FAST_SHDN_EN is defined.
package balance_seq_pkg;

    typedef enum logic [2:0] {IDLE, RIDER_WAIT, SETTLE, STEER, FAULT} seq_state_t;

    localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
    localparam logic [11:0] WT_HYST_DEF      = 12'h040;
`ifdef TOO_FAST_SHDN_EN
    localparam int unsigned FAULT_CNT_DEF    = 8;
`endif

    // Short timer in simulation, ~1.34 s at 50 MHz in silicon.
    function automatic int unsigned tmr_width(input bit fast_sim);
        return fast_sim ? 15 : 26;
    endfunction

endpackage

// File: rtl/balance_seq_rider_detect.sv
// Load-cell rider presence (with hysteresis) and left/right balance decision.
// Decisions update only on ld_vld; otherwise the previous decision holds.
module balance_seq_rider_detect
    import balance_seq_pkg::*;
#(
    parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
    parameter logic [11:0] WT_HYST      = WT_HYST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        rider_on_d,
    output logic        rider_on_q,
    output logic        balanced_d
);

    localparam logic [12:0] ON_THR  = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
    localparam logic [12:0] OFF_THR = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    logic [12:0] sum;
    logic [11:0] diff;
    logic        balanced_q;

    always_comb begin
        sum        = {1'b0, lft_ld} + {1'b0, rght_ld};
        diff       = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
        rider_on_d = rider_on_q;
        balanced_d = balanced_q;
        if (ld_vld) begin
            if (sum > ON_THR)
                rider_on_d = 1'b1;
            else if (sum < OFF_THR)
                rider_on_d = 1'b0;
            balanced_d = ({1'b0, diff} < (sum >> 2));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rider_on_q <= 1'b0;
            balanced_q <= 1'b0;
        end else begin
            rider_on_q <= rider_on_d;
            balanced_q <= balanced_d;
        end
    end

endmodule

// File: rtl/balance_seq.sv
// Run-mode sequencer: orders power-up, rider mount/dismount and steering enable for balance_cntrl.
// Define TOO_FAST_SHDN_EN to add the latched overspeed FAULT state; otherwise fault is tied low.
module balance_seq
    import balance_seq_pkg::*;
#(
    parameter bit          fast_sim     = 1'b1,
    parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
    parameter logic [11:0] WT_HYST      = WT_HYST_DEF
`ifdef TOO_FAST_SHDN_EN
    , parameter int unsigned FAULT_CNT  = FAULT_CNT_DEF
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        stop,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        too_fast,
    output logic        pwr_up,
    output logic        rider_off,
    output logic        en_steer,
    output logic        fault
);

    localparam int unsigned TW = tmr_width(fast_sim);

    seq_state_t    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          stop_pend_q, stop_pend_d;
    logic          pwr_up_q, pwr_up_d;
    logic          en_steer_q, en_steer_d;
    logic          rider_on, rider_on_q, balanced;
    logic          go_eff, pend;

    // The FSM uses this cycle's load decision so it reacts in step with rider_off.
    balance_seq_rider_detect #(
        .MIN_RIDER_WT(MIN_RIDER_WT),
        .WT_HYST     (WT_HYST)
    ) u_rider_detect (
        .clk       (clk),
        .rst       (rst),
        .ld_vld    (ld_vld),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .rider_on_d(rider_on),
        .rider_on_q(rider_on_q),
        .balanced_d(balanced)
    );

`ifdef TOO_FAST_SHDN_EN
    localparam int unsigned    CW      = $clog2(FAULT_CNT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FAULT_CNT);

    logic [CW-1:0] fcnt_q, fcnt_d;
    logic          fault_q, fault_d;
    logic          shdn;

    always_comb begin
        fcnt_d = '0;
        if (too_fast)
            fcnt_d = (fcnt_q == CNT_MAX) ? fcnt_q : fcnt_q + 1'b1;
        shdn = (fcnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // stop beats go when both arrive together.
    assign go_eff = go && !stop;
    assign pend   = stop_pend_q && !go_eff;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        stop_pend_d = pend;
        unique case (state_q)
            IDLE: begin
                if (go_eff)
                    state_d = RIDER_WAIT;
            end
            RIDER_WAIT: begin
                if (stop || (pend && !rider_on)) begin
                    state_d = IDLE;
                end else if (rider_on && balanced) begin
                    state_d = SETTLE;
                    tmr_d   = '0;
                end
            end
            SETTLE: begin
                if (stop)
                    stop_pend_d = 1'b1;
                if (!rider_on) begin
                    state_d = RIDER_WAIT;
                end else if (!balanced) begin
                    tmr_d = '0;
                end else if (&tmr_q) begin
                    state_d = STEER;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            STEER: begin
                // Power stays up under a rider; the stop is honoured after dismount.
                if (stop)
                    stop_pend_d = 1'b1;
                if (!rider_on)
                    state_d = RIDER_WAIT;
            end
`ifdef TOO_FAST_SHDN_EN
            FAULT: begin
                if (go_eff && !too_fast && !rider_on)
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

`ifdef TOO_FAST_SHDN_EN
        if (shdn && (state_q inside {RIDER_WAIT, SETTLE, STEER}))
            state_d = FAULT;
        fault_d    = (state_d == FAULT);
        en_steer_d = (state_d == STEER);
`else
        en_steer_d = (state_d == STEER) && !too_fast;
`endif
        if (state_d == IDLE)
            stop_pend_d = 1'b0;
        pwr_up_d = state_d inside {RIDER_WAIT, SETTLE, STEER};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            stop_pend_q <= 1'b0;
            pwr_up_q    <= 1'b0;
            en_steer_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            stop_pend_q <= stop_pend_d;
            pwr_up_q    <= pwr_up_d;
            en_steer_q  <= en_steer_d;
        end
    end

    assign pwr_up    = pwr_up_q;
    assign en_steer  = en_steer_q;
    assign rider_off = !rider_on_q;

endmodule

// File: tb/tb_balance_seq.sv
// Directed scoreboard bench for balance_seq (fast_sim=1); covers both TOO_FAST_SHDN_EN builds.
module tb_balance_seq;

    logic        clk = 1'b0;
    logic        rst, go, stop, ld_vld, too_fast;
    logic [11:0] lft_ld, rght_ld;
    logic        pwr_up, rider_off, en_steer, fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] exp;   // {pwr_up, rider_off, en_steer, fault}
    } exp_t;
    exp_t sb[$];

    balance_seq dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .stop     (stop),
        .ld_vld   (ld_vld),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .too_fast (too_fast),
        .pwr_up   (pwr_up),
        .rider_off(rider_off),
        .en_steer (en_steer),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input logic p, input logic o,
                              input logic s, input logic f);
        exp_t e;
        e.tag = tag;
        e.exp = {p, o, s, f};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t       e;
        logic [3:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {pwr_up, rider_off, en_steer, fault};
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed pwr/off/steer/fault=%b expected %b", e.tag, obs, e.exp);
            end
        end
    endtask

    // One valid load sample, consumed at the next clock edge.
    task automatic load(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
        ld_vld  = 1'b1;
        tick();
        ld_vld  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; go = 1'b0; stop = 1'b0; ld_vld = 1'b0; too_fast = 1'b0;
        lft_ld = '0; rght_ld = '0;
        #1 rst = 1'b1;
        #1;
        expect_out("reset", 0, 1, 0, 0); check();
        tick(2);
        rst = 1'b0;
        expect_out("idle_hold", 0, 1, 0, 0); tick(3); check();

        // Power-up and mount
        go = 1'b1;
        expect_out("go_rider_wait", 1, 1, 0, 0); tick(); go = 1'b0; check();
        expect_out("mount_settle", 1, 0, 0, 0); load(12'h180, 12'h180); check();
        tick(100);

        // Imbalance clears the settle timer; rebalance restarts the full count
        expect_out("unbal_hold", 1, 0, 0, 0); load(12'h300, 12'h020); tick(200); check();
        expect_out("rebal", 1, 0, 0, 0); load(12'h180, 12'h180); check();
        // The rebalancing sample is the first counted cycle: 2^15-1 more edges to STEER.
        expect_out("rebal_not_yet", 1, 0, 0, 0); tick(2**15 - 2); check();
        expect_out("rebal_steer", 1, 0, 1, 0); tick(); check();

        // Overspeed in STEER
`ifdef TOO_FAST_SHDN_EN
        too_fast = 1'b1;
        expect_out("tf7_no_fault", 1, 0, 1, 0); tick(7); too_fast = 1'b0; check();
        expect_out("tf7_after", 1, 0, 1, 0); tick(); check();
`else
        too_fast = 1'b1;
        expect_out("tf_steer_drop", 1, 0, 0, 0); tick(); too_fast = 1'b0; check();
        expect_out("tf_steer_back", 1, 0, 1, 0); tick(); check();
        expect_out("tf_no_fault", 1, 0, 1, 0); tick(3); check();
`endif

        // Sum inside the hysteresis band never drops the rider
        for (int i = 0; i < 4; i++) begin
            expect_out("osc_1d0", 1, 0, 1, 0); load(12'h0E8, 12'h0E8); check();
            expect_out("osc_230", 1, 0, 1, 0); load(12'h118, 12'h118); check();
        end

        // stop under a rider is deferred until dismount
        stop = 1'b1;
        expect_out("stop_steer", 1, 0, 1, 0); tick(); stop = 1'b0; check();
        expect_out("stop_held", 1, 0, 1, 0); tick(5); check();
        expect_out("dismount_1b0", 1, 1, 0, 0); load(12'h0D8, 12'h0D8); check();
        expect_out("pend_idle", 0, 1, 0, 0); tick(); check();

        go = 1'b1; stop = 1'b1;
        expect_out("go_stop_idle", 0, 1, 0, 0); tick(); go = 1'b0; stop = 1'b0; check();
        expect_out("go_stop_stay", 0, 1, 0, 0); tick(3); check();

        // Clean entry: STEER exactly 2^15 edges after entering SETTLE
        go = 1'b1;
        expect_out("go2_rider_wait", 1, 1, 0, 0); tick(); go = 1'b0; check();
        expect_out("mount2_settle", 1, 0, 0, 0); load(12'h180, 12'h180); check();
        expect_out("settle_not_yet", 1, 0, 0, 0); tick(2**15 - 1); check();
        expect_out("settle_steer", 1, 0, 1, 0); tick(); check();

        // Async reset mid-STEER takes effect without a clock edge
        tick(3);
        #1 rst = 1'b1;
        #1;
        expect_out("rst_mid_steer", 0, 1, 0, 0); check();
        tick(2);
        rst = 1'b0;
        expect_out("rst_released", 0, 1, 0, 0); tick(5); check();
        expect_out("idle_rider_only", 0, 0, 0, 0); load(12'h180, 12'h180); check();
        expect_out("idle_no_pwr", 0, 0, 0, 0); tick(3); check();

`ifdef TOO_FAST_SHDN_EN
        // Overspeed shutdown from SETTLE and gated exit
        go = 1'b1;
        expect_out("go3_rider_wait", 1, 0, 0, 0); tick(); go = 1'b0; check();
        expect_out("settle3", 1, 0, 0, 0); tick(); check();
        too_fast = 1'b1;
        expect_out("tf7_settle", 1, 0, 0, 0); tick(7); check();
        expect_out("tf8_fault", 0, 0, 0, 1); tick(); too_fast = 1'b0; check();
        go = 1'b1;
        expect_out("fault_rider_on", 0, 0, 0, 1); tick(); go = 1'b0; check();
        expect_out("fault_dismount", 0, 1, 0, 1); load(12'h000, 12'h000); check();
        go = 1'b1; too_fast = 1'b1;
        expect_out("fault_tf_high", 0, 1, 0, 1); tick(); go = 1'b0; too_fast = 1'b0; check();
        go = 1'b1;
        expect_out("fault_exit", 0, 1, 0, 0); tick(); go = 1'b0; check();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
